// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: register/cause widths and the reorder-buffer entry record.
package ooo_pkg;

    localparam int unsigned GPR_ADDR_W  = 5;
    localparam int unsigned EXC_CAUSE_W = 4;
    localparam int unsigned ROB_XLEN    = 32;

    typedef struct packed {
        logic                   valid;
        logic                   done;
        logic                   mispred;
        logic                   exc;
        logic                   dst_wen;
        logic [GPR_ADDR_W-1:0]  dst_addr;
        logic [ROB_XLEN-1:0]    pc;
        logic [ROB_XLEN-1:0]    data;
        logic [ROB_XLEN-1:0]    target;
        logic [EXC_CAUSE_W-1:0] cause;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_sel.sv
// Retire-slot selection: picks the in-order prefix of completed entries, stopping after the
// first entry that will redirect the pipeline.
module rob_commit_sel #(
    parameter int unsigned COMMIT_W = 2,
    parameter int unsigned TW       = 5,
    localparam int unsigned RW      = $clog2(COMMIT_W + 1)
) (
    input  logic [COMMIT_W-1:0] valid,
    input  logic [COMMIT_W-1:0] done,
    input  logic [COMMIT_W-1:0] mispred,
    input  logic [COMMIT_W-1:0] exc,
    input  logic [TW:0]         count,
    output logic [COMMIT_W-1:0] slot_valid,
    output logic [RW-1:0]       retire_cnt
);

    logic run;

    always_comb begin
        run        = 1'b1;
        retire_cnt = '0;
        slot_valid = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_valid[k] = run && valid[k] && done[k] && ((TW + 1)'(k) < count);
            run           = slot_valid[k] && !mispred[k] && !exc[k];
            retire_cnt    = retire_cnt + RW'(slot_valid[k]);
        end
    end

endmodule

// File: rtl/rob_mp.sv
// Multi-port reorder buffer with in-order retirement of up to COMMIT_W entries per cycle.
// Define ROB_MP_BYPASS_EN to forward same-cycle writebacks into the registered operand lookup.
module rob_mp
    import ooo_pkg::*;
#(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned WB_PORTS = 4,
    parameter int unsigned COMMIT_W = 2,
    parameter int unsigned XLEN     = ROB_XLEN,
    localparam int unsigned TW      = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic [XLEN-1:0]               alloc_pc,
    input  logic [GPR_ADDR_W-1:0]         alloc_dst_addr,
    input  logic                          alloc_dst_wen,
    output logic [TW-1:0]                 alloc_tag,
    input  logic [WB_PORTS-1:0]           wb_valid,
    input  logic [WB_PORTS*TW-1:0]        wb_tag,
    input  logic [WB_PORTS*XLEN-1:0]      wb_data,
    input  logic                          br_valid,
    input  logic [TW-1:0]                 br_tag,
    input  logic                          br_mispred,
    input  logic [XLEN-1:0]               br_target,
    input  logic                          exc_valid,
    input  logic [TW-1:0]                 exc_tag,
    input  logic [EXC_CAUSE_W-1:0]        exc_cause,
    input  logic [2*TW-1:0]               rd_tag,
    output logic [1:0]                    rd_hit,
    output logic [2*XLEN-1:0]             rd_data,
    output logic [COMMIT_W-1:0]           commit_valid,
    output logic [COMMIT_W-1:0]           commit_wen,
    output logic [COMMIT_W*GPR_ADDR_W-1:0] commit_dst_addr,
    output logic [COMMIT_W*XLEN-1:0]      commit_data,
    output logic [COMMIT_W*TW-1:0]        commit_tag,
    output logic                          flush,
    output logic [XLEN-1:0]               flush_pc,
    output logic                          exc_commit,
    output logic [EXC_CAUSE_W-1:0]        exc_commit_cause,
    output logic [XLEN-1:0]               exc_commit_pc,
    output logic [TW:0]                   count
);

    localparam int unsigned RW = $clog2(COMMIT_W + 1);

    rob_entry_t          ents_q [DEPTH];
    rob_entry_t          ents_d [DEPTH];
    logic [TW:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [TW-1:0]       slot_idx [COMMIT_W];
    logic [COMMIT_W-1:0] ord_valid, ord_done, ord_mispred, ord_exc, slot_valid;
    logic [RW-1:0]       retire_cnt;
    logic                full, alloc_fire;
    logic [TW-1:0]       rd_t [2];
    logic [1:0]          rd_hit_d;
    logic [2*XLEN-1:0]   rd_data_d;

    assign count       = wptr_q - rptr_q;
    assign full        = (count == (TW + 1)'(DEPTH));
    // Held low while in reset so every output reads 0 until release.
    assign alloc_ready = !rst && !full && !flush;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = wptr_q[TW-1:0];

    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_idx[k]    = rptr_q[TW-1:0] + TW'(k);
            ord_valid[k]   = ents_q[slot_idx[k]].valid;
            ord_done[k]    = ents_q[slot_idx[k]].done;
            ord_mispred[k] = ents_q[slot_idx[k]].mispred;
            ord_exc[k]     = ents_q[slot_idx[k]].exc;
        end
    end

    rob_commit_sel #(
        .COMMIT_W (COMMIT_W),
        .TW       (TW)
    ) u_commit_sel (
        .valid      (ord_valid),
        .done       (ord_done),
        .mispred    (ord_mispred),
        .exc        (ord_exc),
        .count      (count),
        .slot_valid (slot_valid),
        .retire_cnt (retire_cnt)
    );

    assign commit_valid = slot_valid;

    always_comb begin
        commit_wen       = '0;
        commit_dst_addr  = '0;
        commit_data      = '0;
        commit_tag       = '0;
        flush            = 1'b0;
        flush_pc         = '0;
        exc_commit       = 1'b0;
        exc_commit_cause = '0;
        exc_commit_pc    = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (slot_valid[k]) begin
                commit_wen[k] = ents_q[slot_idx[k]].dst_wen && !ents_q[slot_idx[k]].exc;
                commit_dst_addr[k*GPR_ADDR_W +: GPR_ADDR_W] = ents_q[slot_idx[k]].dst_addr;
                commit_data[k*XLEN +: XLEN] = ents_q[slot_idx[k]].data;
                commit_tag[k*TW +: TW]      = slot_idx[k];
                // Only the last valid slot can carry a redirect; earlier ones block on it.
                if (ents_q[slot_idx[k]].mispred || ents_q[slot_idx[k]].exc) flush = 1'b1;
                if (ents_q[slot_idx[k]].mispred && !ents_q[slot_idx[k]].exc) begin
                    flush_pc = ents_q[slot_idx[k]].target;
                end
                if (ents_q[slot_idx[k]].exc) begin
                    exc_commit       = 1'b1;
                    exc_commit_cause = ents_q[slot_idx[k]].cause;
                    exc_commit_pc    = ents_q[slot_idx[k]].pc;
                end
            end
        end
    end

    always_comb begin
        ents_d = ents_q;
        rptr_d = rptr_q + (TW + 1)'(retire_cnt);
        wptr_d = wptr_q;
        if (alloc_fire) begin
            ents_d[alloc_tag]          = '0;
            ents_d[alloc_tag].valid    = 1'b1;
            ents_d[alloc_tag].dst_wen  = alloc_dst_wen;
            ents_d[alloc_tag].dst_addr = alloc_dst_addr;
            ents_d[alloc_tag].pc       = alloc_pc;
            wptr_d = wptr_q + (TW + 1)'(1);
        end
        // Highest port first so the lowest-indexed hit overwrites last and wins.
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (wb_valid[p] && ents_q[wb_tag[p*TW +: TW]].valid) begin
                ents_d[wb_tag[p*TW +: TW]].done = 1'b1;
                ents_d[wb_tag[p*TW +: TW]].data = wb_data[p*XLEN +: XLEN];
            end
        end
        if (br_valid && ents_q[br_tag].valid) begin
            ents_d[br_tag].done = 1'b1;
            if (br_mispred) begin
                ents_d[br_tag].mispred = 1'b1;
                ents_d[br_tag].target  = br_target;
            end
        end
        if (exc_valid && ents_q[exc_tag].valid) begin
            ents_d[exc_tag].done  = 1'b1;
            ents_d[exc_tag].exc   = 1'b1;
            ents_d[exc_tag].cause = exc_cause;
        end
        for (int k = 0; k < COMMIT_W; k++) begin
            if (slot_valid[k]) ents_d[slot_idx[k]].valid = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) ents_d[i].valid = 1'b0;
            wptr_d = rptr_d;
        end
    end

    always_comb begin
        rd_hit_d  = '0;
        rd_data_d = '0;
        for (int j = 0; j < 2; j++) begin
            rd_t[j]     = rd_tag[j*TW +: TW];
            rd_hit_d[j] = ents_q[rd_t[j]].valid && ents_q[rd_t[j]].done;
            rd_data_d[j*XLEN +: XLEN] = ents_q[rd_t[j]].data;
`ifdef ROB_MP_BYPASS_EN
            for (int p = WB_PORTS - 1; p >= 0; p--) begin
                if (wb_valid[p] && (wb_tag[p*TW +: TW] == rd_t[j]) && ents_q[rd_t[j]].valid) begin
                    rd_hit_d[j] = 1'b1;
                    rd_data_d[j*XLEN +: XLEN] = wb_data[p*XLEN +: XLEN];
                end
            end
`endif
            if (!rd_hit_d[j]) rd_data_d[j*XLEN +: XLEN] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rd_hit  <= '0;
            rd_data <= '0;
            for (int i = 0; i < DEPTH; i++) ents_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rd_hit  <= rd_hit_d;
            rd_data <= rd_data_d;
            for (int i = 0; i < DEPTH; i++) ents_q[i] <= ents_d[i];
        end
    end

endmodule

// File: tb/tb_rob_mp.sv
// Bench for rob_mp (DEPTH=8): directed scenarios plus randomized traffic against a queue model.
module tb_rob_mp;

    logic        clk, rst;
    logic        alloc_valid, alloc_ready;
    logic [31:0] alloc_pc;
    logic [4:0]  alloc_dst_addr;
    logic        alloc_dst_wen;
    logic [2:0]  alloc_tag;
    logic [3:0]  wb_valid;
    logic [11:0] wb_tag;
    logic [127:0] wb_data;
    logic        br_valid, br_mispred;
    logic [2:0]  br_tag;
    logic [31:0] br_target;
    logic        exc_valid;
    logic [2:0]  exc_tag;
    logic [3:0]  exc_cause;
    logic [5:0]  rd_tag;
    logic [1:0]  rd_hit;
    logic [63:0] rd_data;
    logic [1:0]  commit_valid, commit_wen;
    logic [9:0]  commit_dst_addr;
    logic [63:0] commit_data;
    logic [5:0]  commit_tag;
    logic        flush, exc_commit;
    logic [31:0] flush_pc, exc_commit_pc;
    logic [3:0]  exc_commit_cause;
    logic [3:0]  count;

    rob_mp #(.DEPTH(8), .WB_PORTS(4), .COMMIT_W(2), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
        .alloc_dst_addr(alloc_dst_addr), .alloc_dst_wen(alloc_dst_wen), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .br_valid(br_valid), .br_tag(br_tag), .br_mispred(br_mispred), .br_target(br_target),
        .exc_valid(exc_valid), .exc_tag(exc_tag), .exc_cause(exc_cause),
        .rd_tag(rd_tag), .rd_hit(rd_hit), .rd_data(rd_data),
        .commit_valid(commit_valid), .commit_wen(commit_wen),
        .commit_dst_addr(commit_dst_addr), .commit_data(commit_data), .commit_tag(commit_tag),
        .flush(flush), .flush_pc(flush_pc),
        .exc_commit(exc_commit), .exc_commit_cause(exc_commit_cause),
        .exc_commit_pc(exc_commit_pc), .count(count)
    );

`ifdef ROB_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Model: in-flight tags oldest first, plus per-tag attributes.
    int          q[$];
    int          wp, rp;
    bit          m_done[8], m_misp[8], m_exc[8], m_wen[8];
    logic [31:0] m_pc[8], m_data[8], m_tgt[8];
    logic [4:0]  m_dst[8];
    logic [3:0]  m_cause[8];
    logic [1:0]  e_rd_hit;
    logic [31:0] e_rd_data[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endfunction

    function automatic bit in_rob(input int t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        q.delete();
        wp = 0;
        rp = 0;
        e_rd_hit = '0;
        e_rd_data[0] = '0;
        e_rd_data[1] = '0;
    endfunction

    // Check current outputs against the model, then advance the model by this cycle's inputs.
    function automatic void model_step();
        int n, ft, t;
        bit fl, rdy;
        bit written[8];
        logic [1:0]  nh;
        logic [31:0] nd[2];
        n = 0; ft = 0; fl = 0;
        for (int k = 0; k < 2 && k < q.size(); k++) begin
            t = q[k];
            if (!m_done[t]) break;
            n++;
            if (m_misp[t] || m_exc[t]) begin fl = 1; ft = t; break; end
        end
        rdy = (q.size() < 8) && !fl;
        chk("count", 64'(count), 64'(q.size()));
        chk("alloc_ready", 64'(alloc_ready), 64'(rdy));
        chk("alloc_tag", 64'(alloc_tag), 64'(wp % 8));
        chk("commit_valid", 64'(commit_valid), 64'((1 << n) - 1));
        chk("flush", 64'(flush), 64'(fl));
        chk("exc_commit", 64'(exc_commit), 64'(fl && m_exc[ft]));
        if (fl && m_misp[ft] && !m_exc[ft]) chk("flush_pc", 64'(flush_pc), 64'(m_tgt[ft]));
        if (fl && m_exc[ft]) begin
            chk("exc_cause", 64'(exc_commit_cause), 64'(m_cause[ft]));
            chk("exc_pc", 64'(exc_commit_pc), 64'(m_pc[ft]));
        end
        for (int k = 0; k < n; k++) begin
            t = q[k];
            chk("commit_tag", 64'(commit_tag[k*3 +: 3]), 64'(t));
            chk("commit_data", 64'(commit_data[k*32 +: 32]), 64'(m_data[t]));
            chk("commit_dst", 64'(commit_dst_addr[k*5 +: 5]), 64'(m_dst[t]));
            chk("commit_wen", 64'(commit_wen[k]), 64'(m_wen[t] && !m_exc[t]));
        end
        chk("rd_hit", 64'(rd_hit), 64'(e_rd_hit));
        for (int j = 0; j < 2; j++)
            if (e_rd_hit[j]) chk("rd_data", 64'(rd_data[j*32 +: 32]), 64'(e_rd_data[j]));

        for (int j = 0; j < 2; j++) begin
            t = int'(rd_tag[j*3 +: 3]);
            nh[j] = in_rob(t) && m_done[t];
            nd[j] = m_data[t];
            if (BYP && in_rob(t)) begin
                for (int p = 0; p < 4; p++) begin
                    if (wb_valid[p] && int'(wb_tag[p*3 +: 3]) == t) begin
                        nh[j] = 1'b1;
                        nd[j] = wb_data[p*32 +: 32];
                        break;
                    end
                end
            end
        end
        e_rd_hit = nh;
        e_rd_data[0] = nd[0];
        e_rd_data[1] = nd[1];

        foreach (written[i]) written[i] = 1'b0;
        for (int p = 0; p < 4; p++) begin
            t = int'(wb_tag[p*3 +: 3]);
            if (wb_valid[p] && in_rob(t) && !written[t]) begin
                written[t] = 1'b1;
                m_done[t]  = 1'b1;
                m_data[t]  = wb_data[p*32 +: 32];
            end
        end
        t = int'(br_tag);
        if (br_valid && in_rob(t)) begin
            m_done[t] = 1'b1;
            if (br_mispred) begin m_misp[t] = 1'b1; m_tgt[t] = br_target; end
        end
        t = int'(exc_tag);
        if (exc_valid && in_rob(t)) begin
            m_done[t] = 1'b1; m_exc[t] = 1'b1; m_cause[t] = exc_cause;
        end
        repeat (n) void'(q.pop_front());
        rp += n;
        if (fl) begin q.delete(); wp = rp; end
        if (alloc_valid && rdy) begin
            t = wp % 8;
            q.push_back(t);
            m_done[t] = 0; m_misp[t] = 0; m_exc[t] = 0; m_data[t] = '0;
            m_pc[t] = alloc_pc; m_dst[t] = alloc_dst_addr; m_wen[t] = alloc_dst_wen;
            wp++;
        end
    endfunction

    always @(negedge clk) if (chk_en) model_step();

    task automatic idle();
        alloc_valid = 0; wb_valid = '0; br_valid = 0; br_mispred = 0; exc_valid = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_wb(input int p, input int t, input logic [31:0] d);
        wb_valid[p] = 1'b1;
        wb_tag[p*3 +: 3] = 3'(t);
        wb_data[p*32 +: 32] = d;
    endtask

    task automatic alloc_n(input int n);
        alloc_valid = 1;
        for (int i = 0; i < n; i++) begin
            alloc_pc = 32'h1000 + 32'(4 * i);
            alloc_dst_addr = 5'(i + 1);
            alloc_dst_wen = 1;
            tick();
        end
        alloc_valid = 0;
    endtask

    task automatic do_reset();
        chk_en = 0;
        #1 rst = 1;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd0);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_rd_hit", 64'(rd_hit), 64'd0);
        idle();
        @(posedge clk);
        #2 rst = 0;
        model_reset();
        #1 chk("release_alloc_ready", 64'(alloc_ready), 64'd1);
        chk_en = 1;
    endtask

    function automatic int pick_tag();
        if (q.size() > 0 && $urandom_range(3) != 0) return q[$urandom_range(q.size() - 1)];
        return int'($urandom_range(7));
    endfunction

    task automatic rand_cycle();
        idle();
        alloc_valid = ($urandom_range(9) < 7);
        alloc_pc = $urandom;
        alloc_dst_addr = 5'($urandom);
        alloc_dst_wen = 1'($urandom);
        for (int p = 0; p < 4; p++) if ($urandom_range(1) == 1) set_wb(p, pick_tag(), $urandom);
        if ($urandom_range(4) == 0) begin
            br_valid = 1; br_tag = 3'(pick_tag());
            br_mispred = ($urandom_range(7) == 0); br_target = $urandom;
        end
        if ($urandom_range(19) == 0) begin
            exc_valid = 1; exc_tag = 3'(pick_tag()); exc_cause = 4'($urandom);
        end
        rd_tag = {3'(pick_tag()), 3'(pick_tag())};
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; idle();
        alloc_pc = '0; alloc_dst_addr = '0; alloc_dst_wen = 0;
        wb_tag = '0; wb_data = '0; br_tag = '0; br_target = '0;
        exc_tag = '0; exc_cause = '0; rd_tag = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_alloc_ready", 64'(alloc_ready), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_flush", 64'(flush | exc_commit), 64'd0);
        chk("reset_commit", 64'(commit_valid), 64'd0);
        rst = 0;
        model_reset();
        #1 chk("release_alloc_ready", 64'(alloc_ready), 64'd1);
        chk_en = 1;

        // Fill and drain
        alloc_n(8);
        chk("s1_count_full", 64'(count), 64'd8);
        chk("s1_ready_full", 64'(alloc_ready), 64'd0);
        for (int p = 0; p < 4; p++) set_wb(p, p, 32'hD0 + 32'(p));
        tick();
        wb_valid = '0;
        for (int p = 0; p < 4; p++) set_wb(p, p + 4, 32'hD4 + 32'(p));
        chk("s1_cv0", 64'(commit_valid), 64'd3);
        chk("s1_tag0", 64'(commit_tag), 64'd8);
        chk("s1_full_commit_ready", 64'(alloc_ready), 64'd0);
        tick();
        wb_valid = '0;
        chk("s1_ready_after", 64'(alloc_ready), 64'd1);
        chk("s1_count6", 64'(count), 64'd6);
        chk("s1_tag1", 64'(commit_tag), 64'd26);
        tick();
        chk("s1_tag2", 64'(commit_tag), 64'd44);
        tick();
        chk("s1_tag3", 64'(commit_tag), 64'd62);
        chk("s1_cv3", 64'(commit_valid), 64'd3);
        tick();
        chk("s1_empty", 64'(count), 64'd0);
        chk("s1_ready_end", 64'(alloc_ready), 64'd1);

        // Out-of-order completion, across the wrap bit
        alloc_n(3);
        set_wb(0, 2, 32'h22); tick(); wb_valid = '0;
        chk("s2_none_a", 64'(commit_valid), 64'd0);
        set_wb(0, 1, 32'h11); tick(); wb_valid = '0;
        chk("s2_none_b", 64'(commit_valid), 64'd0);
        set_wb(0, 0, 32'h10); tick(); wb_valid = '0;
        chk("s2_pair", 64'(commit_valid), 64'd3);
        chk("s2_pair_tag", 64'(commit_tag), 64'd8);
        tick();
        chk("s2_last", 64'(commit_valid), 64'd1);
        chk("s2_last_tag", 64'(commit_tag[2:0]), 64'd2);
        tick();

        // Mispredict squash
        alloc_n(2);
        set_wb(0, 4, 32'h44);
        br_valid = 1; br_tag = 3'd3; br_mispred = 1; br_target = 32'h100;
        tick(); idle();
        chk("s3_cv", 64'(commit_valid), 64'd1);
        chk("s3_tag", 64'(commit_tag[2:0]), 64'd3);
        chk("s3_flush", 64'(flush), 64'd1);
        chk("s3_flush_pc", 64'(flush_pc), 64'h100);
        chk("s3_ready_flush", 64'(alloc_ready), 64'd0);
        tick();
        chk("s3_count0", 64'(count), 64'd0);
        set_wb(0, 4, 32'h99); rd_tag = 6'd4;
        tick(); idle();
        chk("s3_late_cv", 64'(commit_valid), 64'd0);
        tick();
        chk("s3_late_rd", 64'(rd_hit[0]), 64'd0);

        // Reset mid-operation
        alloc_n(2);
        set_wb(0, 4, 32'h7);
        do_reset();

        // Exception
        alloc_valid = 1; alloc_pc = 32'h40; alloc_dst_addr = 5'd3; alloc_dst_wen = 1;
        tick(); alloc_valid = 0;
        exc_valid = 1; exc_tag = 3'd0; exc_cause = 4'd2;
        tick(); idle();
        chk("s4_cv", 64'(commit_valid), 64'd1);
        chk("s4_wen", 64'(commit_wen), 64'd0);
        chk("s4_exc", 64'(exc_commit), 64'd1);
        chk("s4_pc", 64'(exc_commit_pc), 64'h40);
        chk("s4_cause", 64'(exc_commit_cause), 64'd2);
        chk("s4_flush", 64'(flush), 64'd1);
        tick();

        // Port conflict on tag 5
        alloc_n(5);
        set_wb(0, 5, 32'hA); set_wb(2, 5, 32'hB);
        tick(); wb_valid = '0;
        rd_tag = 6'd5;
        tick();
        chk("s5_hit", 64'(rd_hit[0]), 64'd1);
        chk("s5_data", 64'(rd_data[31:0]), 64'hA);

        // Lookup bypass on tag 6
        alloc_n(1);
        rd_tag = {3'd6, 3'd5};
        set_wb(1, 6, 32'h55);
        tick(); wb_valid = '0;
        chk("s6_hit", 64'(rd_hit[1]), 64'(BYP));
        if (BYP) chk("s6_data", 64'(rd_data[63:32]), 64'h55);
        tick();
        chk("s6_hit_late", 64'(rd_hit[1]), 64'd1);
        chk("s6_data_late", 64'(rd_data[63:32]), 64'h55);

        for (int p = 0; p < 4; p++) set_wb(p, p + 1, 32'hE0 + 32'(p));
        tick(); wb_valid = '0;
        for (int i = 0; i < 20 && count != 0; i++) tick();
        chk("drain", 64'(count), 64'd0);

        for (int c = 0; c < 1500; c++) begin
            if (c == 700) do_reset();
            rand_cycle();
        end

        idle();
        tick();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
